// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//
// Purpose:
//   Shared definitions for the branch resolution path:
//   - condition-code encodings (COND_BE .. COND_B)
//   - flag nibble bit positions (FLAG_S/Z/C/V), also used by ALU code
//   - the resolve-unit state enum
//   - a helper that evaluates a condition code against a flag nibble
//
// Ports:
//   none (package)
// ---------------------------------------------------------------------------
package branch_pkg;

    // Condition codes carried on br_cond. 101-111 are reserved, never taken.
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

    // Bit positions inside the S/Z/C/V flag nibble.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Resolve-unit sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REDIR  = 2'b01,
        SQUASH = 2'b10
    } state_t;

    // Predicate of one condition code against a flag nibble.
    // The carry flag does not take part in any of the current predicates.
    function automatic logic cond_taken(input logic [3:0] f, input logic [2:0] cond);
        logic lt;
        logic result;
        lt = f[FLAG_S] ^ f[FLAG_V];
        result = 1'b0;
        case (cond)
            COND_BE:  result = f[FLAG_Z];
            COND_BLT: result = lt;
            COND_BLE: result = f[FLAG_Z] | lt;
            COND_BNE: result = ~f[FLAG_Z];
            COND_B:   result = 1'b1;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage : branch_pkg

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
//
// Purpose:
//   Purely combinational branch-condition evaluator. Given a flag nibble and a
//   condition code, reports whether the branch is taken. Shared between the
//   resolve unit and the decoder's static predictor.
//
// Ports:
//   eff_flags  in   4  flag nibble to test (S,Z,C,V in bits 3..0)
//   br_cond    in   3  condition code (see branch_pkg COND_*)
//   taken      out  1  branch condition is satisfied
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] eff_flags,
    input  logic [2:0] br_cond,
    output logic       taken
);

    // Carry is carried through the interface for completeness but no current
    // predicate looks at it.
    logic unused_carry;
    assign unused_carry = eff_flags[FLAG_C];

    assign taken = cond_taken(eff_flags, br_cond);

endmodule : branch_cond_eval

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Consumer side of the ALU flag interface. Holds the architectural S/Z/C/V
//   flag register, resolves conditional branches against it (with same-cycle
//   bypass of a flag write), issues a registered PC redirect to fetch and
//   then squashes the wrong-path slots that follow a taken branch.
//
// Parameters:
//   WIDTH          PC / branch-target width
//   SQUASH_CYCLES  non-stalled cycles (>=1, redirect cycle included) during
//                  which flag writes and branches are ignored after a taken
//                  branch
//
// Ports:
//   clk             in   1      clock, rising edge
//   rst_n           in   1      asynchronous active-low reset
//   szcv_in         in   4      ALU flags (S,Z,C,V in bits 3..0)
//   flag_we         in   1      latch szcv_in this cycle
//   br_valid        in   1      branch instruction present this cycle
//   br_cond         in   3      condition code
//   br_target       in   WIDTH  branch target address
//   stall           in   1      pipeline stall, freezes all state
//   flush           in   1      external flush, highest priority after reset
//   flags           out  4      architectural flag register
//   redirect_valid  out  1      fetch must load redirect_pc
//   redirect_pc     out  WIDTH  redirect address
//   squash          out  1      kill the instruction in the slot
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       szcv_in,
    input  logic             flag_we,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             squash
);

    // Counter must hold SQUASH_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES + 1) : 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       eff_flags;
    logic             taken;
    logic             flag_load;
    logic             pc_load;

    // A flag write in the same cycle as a branch is visible to that branch.
    assign eff_flags = flag_we ? szcv_in : flags;

    branch_cond_eval u_cond_eval (
        .eff_flags (eff_flags),
        .br_cond   (br_cond),
        .taken     (taken)
    );

    // Only right-path instructions may update the flags: writes arriving
    // while a redirect/squash is in progress belong to wrong-path slots.
    assign flag_load = flag_we & ~stall & ~flush & (state == IDLE);

    // Next-state logic. Flush wins over everything, stall freezes the state,
    // otherwise IDLE resolves branches and REDIR/SQUASH count down the
    // wrong-path window.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_load    = 1'b0;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (br_valid && taken) begin
                        state_next = REDIR;
                        pc_load    = 1'b1;
                    end
                end
                REDIR: begin
                    if (SQUASH_CYCLES == 1) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = SQUASH;
                        cnt_next   = CNT_W'(SQUASH_CYCLES - 1);
                    end
                end
                SQUASH: begin
                    if (cnt == CNT_W'(1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State and squash-window counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Architectural flag register; flush deliberately leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_load) begin
            flags <= szcv_in;
        end
    end

    // Redirect target; keeps its last value while no redirect is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= '0;
        end else if (pc_load) begin
            redirect_pc <= br_target;
        end
    end

    // Outputs are decoded straight from the registered state, so they change
    // only on a clock edge (or immediately on reset).
    assign redirect_valid = (state == REDIR);
    assign squash         = (state != IDLE);

endmodule : branch_resolve_unit
